// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// the width helper for the bit counter.
package serial_add_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Counter must hold 0..WIDTH-1; sized with one spare code for clarity.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_add_full_add.sv
// One-bit full adder slice; the serial adder runs every bit through
// a single instance of this cell.
module serial_add_full_add (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_add.sv
// Bit-serial WIDTH-bit adder: captures operands on start, adds one bit
// per clock LSB first, and presents {cout,sum} with a one-cycle done pulse.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for start; sum/cout hold the last completed result
// ST_RUN  | adding bit cnt of the captured operands, carry in c_reg
module serial_add #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    import serial_add_pkg::*;

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_nx;
    logic [CW-1:0]    cnt;
    logic             c_reg;
    logic             s;
    logic             co;

    serial_add_full_add u_fa (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .ci (c_reg),
        .s  (s),
        .co (co)
    );

    // New bit enters at the MSB; written this way so WIDTH=1 needs no slice.
    always_comb begin
        sum_nx            = sum_sh >> 1;
        sum_nx[WIDTH-1]   = s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            cnt    <= '0;
            c_reg  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        c_reg <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= sum_nx;
                    c_reg  <= co;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum   <= sum_nx;
                        cout  <= co;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add.sv
// Scoreboard bench for serial_add at WIDTH=8 and WIDTH=1: drivers push
// expected {cout,sum} from plain arithmetic, monitors pop on each done.
module tb_serial_add;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    int tests = 0;
    int fails = 0;

    logic [8:0] q8[$];
    logic [1:0] q1[$];
    logic [8:0] last8 = '0;
    logic [1:0] last1 = '0;

    always #5 clk = ~clk;

    serial_add #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_add #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitors: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) begin
                tests++; fails++;
                $display("FAIL u8 unexpected done: got sum %0h cout %0b with nothing pending", sum8, cout8);
            end else begin
                chk("u8 result", {cout8, sum8}, q8.pop_front());
            end
        end
        if (done1) begin
            if (q1.size() == 0) begin
                tests++; fails++;
                $display("FAIL u1 unexpected done: got sum %0h cout %0b with nothing pending", sum1, cout1);
            end else begin
                chk("u1 result", {cout1, sum1}, q1.pop_front());
            end
        end
    end

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input bit junk, input bit chain);
        logic [8:0] hold;
        @(negedge clk);
        if (chain) begin
            chk("u8 done before chained start", done8, 1);
            chk("u8 idle before chained start", busy8, 0);
        end
        start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
        hold  = last8;
        last8 = {1'b0, a} + {1'b0, b} + 9'(c);
        q8.push_back(last8);
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            chk("u8 busy", busy8, 1);
            chk("u8 done early", done8, 0);
            chk("u8 result hold", {cout8, sum8}, hold);
            start8 = junk ? 1'b1 : 1'($urandom);
            if (!junk) start8 = 1'b0;
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        end
    endtask

    task automatic wait_done8();
        @(negedge clk);
        start8 = 1'b0;
        chk("u8 done pulse", done8, 1);
        chk("u8 busy clear", busy8, 0);
    endtask

    task automatic op1(input logic a, input logic b, input logic c,
                       input bit junk, input bit chain);
        logic [1:0] hold;
        @(negedge clk);
        if (chain) chk("u1 done before chained start", done1, 1);
        start1 = 1'b1; a1 = a; b1 = b; cin1 = c;
        hold  = last1;
        last1 = 2'(a) + 2'(b) + 2'(c);
        q1.push_back(last1);
        @(negedge clk);
        chk("u1 busy", busy1, 1);
        chk("u1 result hold", {cout1, sum1}, hold);
        start1 = junk;
        a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
    endtask

    task automatic wait_done1();
        @(negedge clk);
        start1 = 1'b0;
        chk("u1 done pulse", done1, 1);
        chk("u1 busy clear", busy1, 0);
    endtask

    task automatic random8(input int n);
        int g = 1;
        for (int i = 0; i < n; i++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom), bit'($urandom), (i > 0) && (g == 0));
            g = (i == n - 1) ? 1 : int'($urandom_range(0, 2));
            if (g > 0) begin
                wait_done8();
                repeat (g - 1) @(negedge clk);
            end
        end
    endtask

    task automatic random1(input int n);
        int g = 1;
        for (int i = 0; i < n; i++) begin
            op1(1'($urandom), 1'($urandom), 1'($urandom), bit'($urandom), (i > 0) && (g == 0));
            g = (i == n - 1) ? 1 : int'($urandom_range(0, 2));
            if (g > 0) begin
                wait_done1();
                repeat (g - 1) @(negedge clk);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no completion expected finish");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
        start1 = 0; a1 = 0; b1 = 0; cin1 = 0;
        repeat (2) @(negedge clk);
        chk("u8 reset busy", busy8, 0);
        chk("u8 reset done", done8, 0);
        chk("u8 reset sum", {cout8, sum8}, 0);
        chk("u1 reset busy", busy1, 0);
        chk("u1 reset done", done1, 0);
        chk("u1 reset sum", {cout1, sum1}, 0);
        rst = 1'b0;

        op8(8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
        wait_done8();
        chk("T1 sum", sum8, 8'h46);
        chk("T1 cout", cout8, 0);
        op8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        wait_done8();
        chk("T2 sum", sum8, 8'h00);
        chk("T2 cout", cout8, 1);
        op8(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0);
        op8(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
        wait_done8();
        chk("T3 chained sum", {cout8, sum8}, 9'h002);
        op8(8'h10, 8'h20, 1'b0, 1'b1, 1'b0);
        wait_done8();
        chk("T4 sum with ignored starts", {cout8, sum8}, 9'h030);
        repeat (3) @(negedge clk);
        chk("u8 no restart after busy starts", busy8, 0);

        // Abort mid-operation: reset at bit 4, no done may follow.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0;
        repeat (3) begin @(negedge clk); start8 = 1'b0; end
        @(negedge clk);
        rst = 1'b1;
        q8.delete(); q1.delete();
        @(negedge clk);
        chk("T5 busy after reset", busy8, 0);
        chk("T5 done after reset", done8, 0);
        chk("T5 sum after reset", sum8, 0);
        chk("T5 cout after reset", cout8, 0);
        rst = 1'b0;
        last8 = '0; last1 = '0;
        repeat (12) @(negedge clk);

        fork
            random8(600);
            random1(600);
        join
        repeat (3) @(negedge clk);
        chk("u8 outstanding results", q8.size(), 0);
        chk("u1 outstanding results", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
